// File: rtl/tt_um_emern_video_pkg.sv
// Shared video timing package: VGA constants, width helper, FSM encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tt_um_emern_video_pkg;

   // VGA 640x480@60 (25.175 MHz pixel clock)
   localparam int VGA_H_ACTIVE = 640;
   localparam int VGA_H_FP     = 16;
   localparam int VGA_H_SYNC   = 96;
   localparam int VGA_H_BP     = 48;
   localparam int VGA_V_ACTIVE = 480;
   localparam int VGA_V_FP     = 10;
   localparam int VGA_V_SYNC   = 2;
   localparam int VGA_V_BP     = 33;

   // raster generator state encoding
   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   // bits needed to hold 0..n-1, never less than one
   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r = r + 1;
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/tt_um_emern_axis_counter.sv
// One raster axis counter: counts 0..TOTAL-1 on inc, reloads INIT on load/rst.
// Latency: count updates one clock after inc; wrap is combinational from count/inc.
// Backpressure: none; advances whenever inc is high.
module tt_um_emern_axis_counter
   import tt_um_emern_video_pkg::*;
#(
   parameter int TOTAL = 16,
   parameter int INIT  = 0,
   parameter int W     = clog2(TOTAL)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   input  logic         load,
   output logic [W-1:0] count,
   output logic         wrap
);

   localparam logic [W-1:0] LAST  = W'(TOTAL - 1);
   localparam logic [W-1:0] START = W'(INIT);

   // wrap marks the increment that takes the axis from its last value back to 0
   assign wrap = inc && (count == LAST);

   // hold at INIT while loaded, otherwise count and wrap
   always_ff @(posedge clk) begin
      if (rst || load) begin
         count <= START;
      end else if (wrap) begin
         count <= '0;
      end else if (inc) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/tt_um_emern_raster_timing.sv
// Raster timing generator: h/v counters, syncs, display-enable, look-ahead pixel coordinates.
// Latency: every output is registered, one clock behind the timing counter.
// Backpressure: none; free-running on the pixel clock, en only starts/stops at frame boundaries.
module tt_um_emern_raster_timing
   import tt_um_emern_video_pkg::*;
#(
   parameter int  H_ACTIVE  = VGA_H_ACTIVE,
   parameter int  H_FP      = VGA_H_FP,
   parameter int  H_SYNC    = VGA_H_SYNC,
   parameter int  H_BP      = VGA_H_BP,
   parameter int  V_ACTIVE  = VGA_V_ACTIVE,
   parameter int  V_FP      = VGA_V_FP,
   parameter int  V_SYNC    = VGA_V_SYNC,
   parameter int  V_BP      = VGA_V_BP,
   parameter bit  HSYNC_POL = 1'b0,
   parameter bit  VSYNC_POL = 1'b0,
   parameter int  LOOKAHEAD = 1,
   localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP,
   localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP,
   localparam int HW        = clog2(H_TOTAL),
   localparam int VW        = clog2(V_TOTAL)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   output logic          hsync,
   output logic          vsync,
   output logic          de,
   output logic [HW-1:0] pixel_col,
   output logic [VW-1:0] pixel_row,
   output logic          pixel_valid,
   output logic          line_start,
   output logic          frame_start,
   output logic [7:0]    frame_count
);

   // one extra bit so window edges equal to the total still compare correctly
   localparam int HX = HW + 1;
   localparam int VX = VW + 1;

   localparam logic [HX-1:0] H_ACT  = HX'(H_ACTIVE);
   localparam logic [HX-1:0] HS_BEG = HX'(H_ACTIVE + H_FP);
   localparam logic [HX-1:0] HS_END = HX'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [VX-1:0] V_ACT  = VX'(V_ACTIVE);
   localparam logic [VX-1:0] VS_BEG = VX'(V_ACTIVE + V_FP);
   localparam logic [VX-1:0] VS_END = VX'(V_ACTIVE + V_FP + V_SYNC);

   localparam logic [HW-1:0] COL_MAX = HW'(H_ACTIVE - 1);
   localparam logic [VW-1:0] ROW_MAX = VW'(V_ACTIVE - 1);

   logic [0:0]    state;
   logic          run;
   logic [HW-1:0] h, lh;
   logic [VW-1:0] v, lv;
   logic          h_wrap, v_wrap, lh_wrap, lv_wrap;
   logic          lead_wrap_unused;
   logic          active, hs, vs, lead_valid;

   assign run = (state == ST_RUN);

   // the lead counter tracks the frame on its own; its frame wrap has no consumer
   assign lead_wrap_unused = lv_wrap;

   // timing position: parked at (0,0) while idle
   tt_um_emern_axis_counter #(.TOTAL(H_TOTAL), .INIT(0), .W(HW)) u_h (
      .clk(clk), .rst(rst), .inc(run), .load(!run), .count(h), .wrap(h_wrap)
   );
   tt_um_emern_axis_counter #(.TOTAL(V_TOTAL), .INIT(0), .W(VW)) u_v (
      .clk(clk), .rst(rst), .inc(h_wrap), .load(!run), .count(v), .wrap(v_wrap)
   );

   // lead position: LOOKAHEAD clocks ahead of timing, same wrap rules
   tt_um_emern_axis_counter #(.TOTAL(H_TOTAL), .INIT(LOOKAHEAD), .W(HW)) u_lh (
      .clk(clk), .rst(rst), .inc(run), .load(!run), .count(lh), .wrap(lh_wrap)
   );
   tt_um_emern_axis_counter #(.TOTAL(V_TOTAL), .INIT(0), .W(VW)) u_lv (
      .clk(clk), .rst(rst), .inc(lh_wrap), .load(!run), .count(lv), .wrap(lv_wrap)
   );

   assign active     = ({1'b0, h} < H_ACT) && ({1'b0, v} < V_ACT);
   assign hs         = ({1'b0, h} >= HS_BEG) && ({1'b0, h} < HS_END);
   assign vs         = ({1'b0, v} >= VS_BEG) && ({1'b0, v} < VS_END);
   assign lead_valid = ({1'b0, lh} < H_ACT) && ({1'b0, lv} < V_ACT);

   // start as soon as en is seen; stop only on the last pixel of a frame with en low
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else if (!run) begin
         state <= en ? ST_RUN : ST_IDLE;
      end else if (v_wrap && !en) begin
         state <= ST_IDLE;
      end
   end

   // output pins, decoded from the counter state of the previous clock
   always_ff @(posedge clk) begin
      if (rst) begin
         hsync       <= !HSYNC_POL;
         vsync       <= !VSYNC_POL;
         de          <= 1'b0;
         pixel_valid <= 1'b0;
         pixel_col   <= '0;
         pixel_row   <= '0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
         frame_count <= '0;
      end else if (run) begin
         hsync       <= hs ? HSYNC_POL : !HSYNC_POL;
         vsync       <= vs ? VSYNC_POL : !VSYNC_POL;
         de          <= active;
         pixel_valid <= lead_valid;
         // saturate outside the active area so the pixel core never indexes past the edge
         pixel_col   <= lead_valid ? lh : COL_MAX;
         pixel_row   <= lead_valid ? lv : ROW_MAX;
         line_start  <= (h == '0);
         frame_start <= (h == '0) && (v == '0);
         if (v_wrap) begin
            frame_count <= frame_count + 8'd1;
         end
      end else begin
         hsync       <= !HSYNC_POL;
         vsync       <= !VSYNC_POL;
         de          <= 1'b0;
         pixel_valid <= 1'b0;
         pixel_col   <= '0;
         pixel_row   <= '0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end
   end

endmodule

// File: tb/tb_tt_um_emern_raster_timing.sv
// Bench for the raster timing generator on a 16x8 raster (8x4 visible, look-ahead 2).
// Latency: expected outputs are queued per clock and compared after the edge.
// Backpressure: n/a.
module tb_tt_um_emern_raster_timing;

   typedef struct packed {
      logic       hsync;
      logic       vsync;
      logic       de;
      logic       pixel_valid;
      logic [3:0] pixel_col;
      logic [2:0] pixel_row;
      logic       line_start;
      logic       frame_start;
      logic [7:0] frame_count;
   } obs_t;

   localparam obs_t RST_VAL = {1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 3'd0, 1'b0, 1'b0, 8'd0};

   logic       clk, rst, en;
   logic       hsync, vsync, de, pixel_valid, line_start, frame_start;
   logic [3:0] pixel_col;
   logic [2:0] pixel_row;
   logic [7:0] frame_count;
   obs_t       obs;

   int n_cmp  = 0;
   int n_fail = 0;
   int cyc    = 0;

   // reference model: frame position 0..127 plus run flag and frame counter
   bit         m_run = 1'b0;
   int         m_pos = 0;
   logic [7:0] m_fc  = 8'd0;
   obs_t       sb[$];

   tt_um_emern_raster_timing #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .LOOKAHEAD(2)
   ) dut (
      .clk(clk), .rst(rst), .en(en),
      .hsync(hsync), .vsync(vsync), .de(de),
      .pixel_col(pixel_col), .pixel_row(pixel_row), .pixel_valid(pixel_valid),
      .line_start(line_start), .frame_start(frame_start), .frame_count(frame_count)
   );

   assign obs = {hsync, vsync, de, pixel_valid, pixel_col, pixel_row,
                 line_start, frame_start, frame_count};

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // drive one clock of stimulus, queue the model's prediction, check the DUT after the edge
   task automatic drive_cycle(input logic e, input logic r);
      obs_t x, got;
      int h, v, lp, lh, lv;
      @(negedge clk);
      en  = e;
      rst = r;
      x = '0;
      x.hsync = 1'b1;
      x.vsync = 1'b1;
      x.frame_count = m_fc;
      if (r) begin
         m_fc = 8'd0; m_run = 1'b0; m_pos = 0;
         x.frame_count = 8'd0;
      end else if (!m_run) begin
         m_run = e;
      end else begin
         h  = m_pos % 16;
         v  = m_pos / 16;
         lp = (m_pos + 2) % 128;
         lh = lp % 16;
         lv = lp / 16;
         x.hsync       = !((h >= 10) && (h < 13));
         x.vsync       = !((v >= 5) && (v < 7));
         x.de          = (h < 8) && (v < 4);
         x.pixel_valid = (lh < 8) && (lv < 4);
         x.pixel_col   = x.pixel_valid ? 4'(lh) : 4'd7;
         x.pixel_row   = x.pixel_valid ? 3'(lv) : 3'd3;
         x.line_start  = (h == 0);
         x.frame_start = (m_pos == 0);
         if (m_pos == 127) begin
            m_fc = m_fc + 8'd1;
            if (!e) m_run = 1'b0;
         end
         x.frame_count = m_fc;
         m_pos = (m_pos + 1) % 128;
      end
      sb.push_back(x);
      @(posedge clk);
      #1;
      cyc++;
      got = sb.pop_front();
      n_cmp++;
      if (obs !== got) begin
         n_fail++;
         $display("FAIL scoreboard cyc=%0d actual hs=%b vs=%b de=%b pv=%b col=%0d row=%0d ls=%b fs=%b fc=%0d required hs=%b vs=%b de=%b pv=%b col=%0d row=%0d ls=%b fs=%b fc=%0d",
                  cyc, obs.hsync, obs.vsync, obs.de, obs.pixel_valid, obs.pixel_col, obs.pixel_row,
                  obs.line_start, obs.frame_start, obs.frame_count,
                  got.hsync, got.vsync, got.de, got.pixel_valid, got.pixel_col, got.pixel_row,
                  got.line_start, got.frame_start, got.frame_count);
      end
   endtask

   task automatic test_reset();
      int bad = 0;
      drive_cycle(1'b0, 1'b1);
      drive_cycle(1'b0, 1'b1);
      n_cmp++;
      if (obs !== RST_VAL) begin
         n_fail++;
         $display("FAIL reset_values: actual %h required %h", obs, RST_VAL);
      end
      for (int i = 0; i < 50; i++) begin
         drive_cycle(1'b0, 1'b0);
         if (!(hsync === 1'b1 && vsync === 1'b1 && de === 1'b0 && frame_count === 8'd0)) bad++;
      end
      n_cmp++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL idle_hold: %0d bad cycles, required 0", bad);
      end
   endtask

   task automatic test_frame();
      int   fs_t[$];
      int   de_n = 0, hs_n = 0, vs_n = 0, falls = 0, bad_off = 0, ls_t = -100, vs_first = -1;
      logic prev_hs = 1'b1;
      drive_cycle(1'b1, 1'b0);
      drive_cycle(1'b1, 1'b0);
      n_cmp++;
      if (!(frame_start === 1'b1 && line_start === 1'b1 && de === 1'b1)) begin
         n_fail++;
         $display("FAIL first_run: fs=%b ls=%b de=%b, required 1 1 1", frame_start, line_start, de);
      end
      for (int t = 0; t < 256; t++) begin
         if (t > 0) drive_cycle(1'b1, 1'b0);
         if (frame_start === 1'b1) fs_t.push_back(t);
         if (line_start === 1'b1) ls_t = t;
         if (t < 128) begin
            de_n += int'(de);
            hs_n += int'(!hsync);
            vs_n += int'(!vsync);
            if (!hsync && prev_hs) begin
               falls++;
               if (t - ls_t != 10) bad_off++;
            end
            if (!vsync && vs_first < 0) vs_first = t;
         end
         prev_hs = hsync;
      end
      n_cmp++;
      if (de_n != 32) begin n_fail++; $display("FAIL de_count: actual %0d required 32", de_n); end
      n_cmp++;
      if (hs_n != 24 || falls != 8) begin
         n_fail++; $display("FAIL hsync_width: low=%0d pulses=%0d, required 24 and 8", hs_n, falls);
      end
      n_cmp++;
      if (bad_off != 0) begin n_fail++; $display("FAIL hsync_offset: %0d misplaced, required 0", bad_off); end
      n_cmp++;
      if (vs_n != 32 || vs_first != 80) begin
         n_fail++; $display("FAIL vsync_lines: low=%0d first=%0d, required 32 and 80", vs_n, vs_first);
      end
      n_cmp++;
      if (fs_t.size() != 2 || fs_t[1] - fs_t[0] != 128) begin
         n_fail++; $display("FAIL frame_period: starts=%0d, required 2 starts 128 apart", fs_t.size());
      end
   endtask

   task automatic test_lookahead();
      logic [3:0] d1 = 4'd0, d2 = 4'd0;
      int col = 0, n_de = 0, bad_la = 0, bad_clamp = 0;
      for (int i = 0; i < 128; i++) begin
         d2 = d1;
         d1 = pixel_col;
         drive_cycle(1'b1, 1'b0);
         col = line_start ? 0 : col + 1;
         if (i >= 2 && de === 1'b1) begin
            n_de++;
            if (d2 !== 4'(col)) bad_la++;
         end
         if (pixel_valid === 1'b0 && (pixel_col !== 4'd7 || pixel_row !== 3'd3)) bad_clamp++;
      end
      n_cmp++;
      if (bad_la != 0 || n_de != 30) begin
         n_fail++; $display("FAIL lookahead: bad=%0d de_seen=%0d, required 0 and 30", bad_la, n_de);
      end
      n_cmp++;
      if (bad_clamp != 0) begin n_fail++; $display("FAIL clamp: %0d bad cycles, required 0", bad_clamp); end
   endtask

   task automatic test_en_drop();
      logic [7:0] fc0, fcb;
      int de_n = 0, fs_n = 0, idle_bad = 0, fs_mid = 0;
      fc0 = frame_count;
      for (int t = 0; t < 260; t++) begin
         drive_cycle(t < 32, 1'b0);
         de_n += int'(de);
         fs_n += int'(frame_start);
         if (t >= 128 && (hsync !== 1'b1 || vsync !== 1'b1 || de !== 1'b0 ||
                          pixel_valid !== 1'b0 || line_start !== 1'b0)) idle_bad++;
      end
      n_cmp++;
      if (de_n != 32 || fs_n != 1) begin
         n_fail++; $display("FAIL drop_completes: de=%0d fs=%0d, required 32 and 1", de_n, fs_n);
      end
      n_cmp++;
      if (idle_bad != 0) begin n_fail++; $display("FAIL drop_idle: %0d bad cycles, required 0", idle_bad); end
      n_cmp++;
      if (frame_count !== fc0 + 8'd1) begin
         n_fail++; $display("FAIL drop_fc: actual %0d required %0d", frame_count, fc0 + 8'd1);
      end
      drive_cycle(1'b1, 1'b0);
      drive_cycle(1'b1, 1'b0);
      n_cmp++;
      if (frame_start !== 1'b1) begin n_fail++; $display("FAIL restart_fs: actual %b required 1", frame_start); end
      fcb = frame_count;
      for (int t = 1; t <= 128; t++) begin
         drive_cycle((t < 32) || (t >= 80), 1'b0);
         if (t < 128) fs_mid += int'(frame_start);
      end
      n_cmp++;
      if (frame_start !== 1'b1 || fs_mid != 0 || frame_count !== fcb + 8'd1) begin
         n_fail++;
         $display("FAIL no_gap: fs=%b mid=%0d fc=%0d, required 1 0 %0d", frame_start, fs_mid, frame_count, fcb + 8'd1);
      end
   endtask

   task automatic test_rst_mid();
      for (int t = 1; t <= 52; t++) drive_cycle(1'b1, 1'b0);
      drive_cycle(1'b1, 1'b1);
      n_cmp++;
      if (obs !== RST_VAL) begin n_fail++; $display("FAIL rst_mid: actual %h required %h", obs, RST_VAL); end
      drive_cycle(1'b1, 1'b0);
      n_cmp++;
      if (obs !== RST_VAL) begin n_fail++; $display("FAIL rst_idle: actual %h required %h", obs, RST_VAL); end
      drive_cycle(1'b1, 1'b0);
      n_cmp++;
      if (!(frame_start === 1'b1 && line_start === 1'b1 && de === 1'b1 && frame_count === 8'd0)) begin
         n_fail++;
         $display("FAIL rst_restart: fs=%b ls=%b de=%b fc=%0d, required 1 1 1 0", frame_start, line_start, de, frame_count);
      end
   endtask

   task automatic test_wrap256();
      int n = 0;
      while (frame_count !== 8'd255 && n < 33000) begin
         drive_cycle(1'b1, 1'b0);
         n++;
      end
      n_cmp++;
      if (frame_count !== 8'd255) begin n_fail++; $display("FAIL fc_reach: actual %0d required 255", frame_count); end
      n = 0;
      while (frame_count === 8'd255 && n < 200) begin
         drive_cycle(1'b1, 1'b0);
         n++;
      end
      n_cmp++;
      if (frame_count !== 8'd0 || n != 128) begin
         n_fail++; $display("FAIL fc_wrap: actual %0d after %0d clocks, required 0 after 128", frame_count, n);
      end
   endtask

   initial begin
      en  = 1'b0;
      rst = 1'b1;
      test_reset();
      test_frame();
      test_lookahead();
      test_en_drop();
      test_rst_mid();
      test_wrap256();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
